sequential_divider: RTL

SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

---
 rtl/sequential_divider.sv | 120 ++++++++++++
 1 files changed

// File: rtl/sequential_divider.sv
// Unsigned 16-by-8 restoring divider, one quotient bit per clock.
// A zero divisor short-circuits to an all-ones quotient with div_by_zero flagged.
module sequential_divider (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e      state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [15:0] dvd_q, dvd_d;
    logic [7:0]  dsr_q, dsr_d;
    logic [8:0]  prem_q, prem_d;
    logic [15:0] quot_q, quot_d;
    logic [7:0]  rem_q, rem_d;
    logic        dbz_q, dbz_d;

    logic [9:0]  shifted;
    logic [9:0]  diff;
    logic [9:0]  step;
    logic        fits;
    logic [15:0] dvd_step;
    logic        unused_step_msb;

    // dvd_q doubles as the quotient shift register: dividend bits leave at the top
    // while quotient bits enter at the bottom.
    always_comb begin
        shifted         = {prem_q, dvd_q[15]};
        fits            = shifted >= {2'b00, dsr_q};
        diff            = shifted - {2'b00, dsr_q};
        step            = fits ? diff : shifted;
        dvd_step        = {dvd_q[14:0], fits};
        unused_step_msb = step[9];
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        dvd_d   = dvd_q;
        dsr_d   = dsr_q;
        prem_d  = prem_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dvd_d   = dividend;
                    dsr_d   = divisor;
                    prem_d  = '0;
                    count_d = '0;
                    state_d = StCalc;
                end
            end
            StCalc: begin
                if (dsr_q == 8'd0) begin
                    quot_d  = 16'hFFFF;
                    rem_d   = dvd_q[7:0];
                    dbz_d   = 1'b1;
                    state_d = StDone;
                end else begin
                    prem_d  = step[8:0];
                    dvd_d   = dvd_step;
                    count_d = count_q + 4'd1;
                    if (count_q == 4'd15) begin
                        quot_d  = dvd_step;
                        rem_d   = step[7:0];
                        dbz_d   = 1'b0;
                        state_d = StDone;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            count_q <= '0;
            dvd_q   <= '0;
            dsr_q   <= '0;
            prem_q  <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            dvd_q   <= dvd_d;
            dsr_q   <= dsr_d;
            prem_q  <= prem_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;
    assign busy        = (state_q != StIdle);
    assign done        = (state_q == StDone);

endmodule
